// File: rtl/dma_desc_sequencer_if.sv
// rtl/dma_desc_sequencer_if.sv - read request/return channel and forwarded data stream bundle
interface dma_desc_sequencer_if;
   logic [17:0] rd_addr_o;
   logic        rd_valid_o;
   logic        rd_ready_i;
   logic [31:0] rd_dat_i;
   logic        rd_dat_valid_i;
   logic [31:0] m_dat_o;
   logic        m_valid_o;
   logic        m_last_o;

   modport master (
      output rd_addr_o, rd_valid_o, m_dat_o, m_valid_o, m_last_o,
      input  rd_ready_i, rd_dat_i, rd_dat_valid_i
   );

   modport slave (
      input  rd_addr_o, rd_valid_o, m_dat_o, m_valid_o, m_last_o,
      output rd_ready_i, rd_dat_i, rd_dat_valid_i
   );
endinterface

// File: rtl/dma_desc_sequencer.sv
// rtl/dma_desc_sequencer.sv - descriptor-chain read sequencer with outstanding-read tracking
module dma_desc_sequencer #(
   parameter int NDESC     = 32,
   parameter int MAX_OUTST = 15,
   localparam int IW       = $clog2(NDESC),
   localparam int OW       = $clog2(MAX_OUTST + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 desc_wr_i,
   input  logic [IW-1:0]        desc_addr_i,
   input  logic [31:0]          desc_dat_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 event_mode_i,
   input  logic                 evt_ready_i,
   dma_desc_sequencer_if.master bus,
   output logic                 busy_o,
   output logic                 evt_done_o,
   output logic                 err_o,
   output logic [IW-1:0]        cur_desc_o
);

   typedef enum logic [2:0] {IDLE, WAIT_EVT, LOAD, ISSUE, DRAIN, DONE} state_t;

   state_t        state, state_next;
   logic [31:0]   table_q [NDESC];
   logic [IW-1:0] idx;
   logic [17:0]   addr_q;
   logic          inc_q;
   logic          final_q;
   logic [11:0]   remain_q;
   logic [OW-1:0] outst;
   logic [OW-1:0] outst_next;
   logic          discard;
   logic          err_q;
   logic          issue;
   logic          ret;
   logic          desc_end;
   logic          last_entry;
   logic          start_ok;

   assign issue      = bus.rd_valid_o && bus.rd_ready_i;
   // Returns with nothing outstanding (e.g. after a reset mid-run) are dropped
   assign ret        = bus.rd_dat_valid_i && (outst != '0);
   assign outst_next = outst + OW'(issue) - OW'(ret);
   assign last_entry = (idx == IW'(NDESC - 1));
   assign start_ok   = start_i && !abort_i && !discard;
   // A descriptor ends on its last handshake, or at once when its length is zero
   assign desc_end   = (state == ISSUE) &&
                       ((remain_q == 12'd0) || (issue && (remain_q == 12'd1)));

   always_comb begin
      state_next     = state;
      bus.rd_valid_o = 1'b0;
      bus.rd_addr_o  = addr_q;
      busy_o         = 1'b1;
      evt_done_o     = 1'b0;
      err_o          = err_q;
      cur_desc_o     = idx;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (start_ok) state_next = event_mode_i ? WAIT_EVT : LOAD;
         end
         WAIT_EVT: begin
            busy_o = 1'b0;
            if (evt_ready_i) state_next = LOAD;
         end
         LOAD: state_next = ISSUE;
         ISSUE: begin
            bus.rd_valid_o = (remain_q != 12'd0) && (outst < OW'(MAX_OUTST));
            if (desc_end) state_next = (final_q || last_entry) ? DRAIN : LOAD;
         end
         DRAIN: if (outst == '0) state_next = DONE;
         DONE: begin
            evt_done_o = 1'b1;
            state_next = event_mode_i ? WAIT_EVT : IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort_i) state_next = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The table survives reset; it only changes while no run is in progress
   always_ff @(posedge clk_i) begin
      if (rst_n_i && desc_wr_i && !busy_o) begin
         table_q[desc_addr_i] <= desc_dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         idx           <= '0;
         outst         <= '0;
         discard       <= 1'b0;
         err_q         <= 1'b0;
         addr_q        <= '0;
         inc_q         <= 1'b0;
         final_q       <= 1'b0;
         remain_q      <= '0;
         bus.m_dat_o   <= '0;
         bus.m_valid_o <= 1'b0;
         bus.m_last_o  <= 1'b0;
      end else begin
         outst         <= outst_next;
         bus.m_dat_o   <= bus.rd_dat_i;
         bus.m_valid_o <= ret && !discard && !abort_i;
         bus.m_last_o  <= ret && !discard && !abort_i &&
                          (state == DRAIN) && (outst == OW'(1));

         // After an abort, swallow every return still in flight before rearming
         if (abort_i) begin
            discard <= (outst_next != '0);
         end else if (outst_next == '0) begin
            discard <= 1'b0;
         end

         if ((state == IDLE) && start_ok) begin
            idx   <= '0;
            err_q <= 1'b0;
         end
         if ((state == WAIT_EVT) && evt_ready_i && !abort_i) begin
            idx <= '0;
         end

         if (state == LOAD) begin
            addr_q   <= table_q[idx][17:0];
            inc_q    <= table_q[idx][18];
            remain_q <= table_q[idx][30:19];
            final_q  <= table_q[idx][31];
         end

         if (issue) begin
            remain_q <= remain_q - 12'd1;
            if (inc_q) addr_q <= addr_q + 18'd1;
         end

         if (desc_end && !abort_i && !final_q) begin
            if (last_entry) begin
               err_q <= 1'b1;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule
